// File: rtl/fwd_sel_unit.sv
// Forwarding-select and load-use hazard unit for the EX-stage operand muxes.
// Optional stall-cycle counter enabled by defining FWD_STALL_CNT_EN.
module fwd_sel_unit #(
  parameter int RA_W = 2
`ifdef FWD_STALL_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs_a,
  input  logic [RA_W-1:0] id_rs_b,
  input  logic            id_use_a,
  input  logic            id_use_b,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_wr_en,
  input  logic            id_is_load,
  input  logic            flush,
  output logic [1:0]      sel_a,
  output logic [1:0]      sel_b,
  output logic            stall,
  output logic            bubble
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            wr_en;
    logic            is_load;
  } slot_t;

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_EXM  = 2'b01;
  localparam logic [1:0] SEL_MWB  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  slot_t ex_q, mem_q, wb_q;
  logic  load_hit;
  logic  advance;

  // Newest producer wins; a load still in EX has no result yet, so it never forwards.
  function automatic logic [1:0] pick_src(input logic [RA_W-1:0] src,
                                          input logic            use_src,
                                          input slot_t           ex,
                                          input slot_t           mem,
                                          input slot_t           wb);
    if (!use_src)
      return SEL_RF;
    else if (ex.valid && ex.wr_en && !ex.is_load && ex.rd == src)
      return SEL_EXM;
    else if (mem.valid && mem.wr_en && mem.rd == src)
      return SEL_MWB;
    else if (wb.valid && wb.wr_en && wb.rd == src)
      return SEL_HOLD;
    else
      return SEL_RF;
  endfunction

  assign load_hit = ex_q.valid && ex_q.wr_en && ex_q.is_load &&
                    ((id_use_a && id_rs_a == ex_q.rd) ||
                     (id_use_b && id_rs_b == ex_q.rd));

  // Gated by rst so a hazard pending at reset is dropped in the same cycle.
  assign stall   = !rst && id_valid && !flush && load_hit;
  assign advance = id_valid && !stall && !flush;

  // NOTE: all pipeline state uses non-blocking assignments so EX->MEM->WB
  // shifts read the pre-edge slot values, exactly like real flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      sel_a  <= SEL_RF;
      sel_b  <= SEL_RF;
      bubble <= 1'b0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (advance) begin
        ex_q  <= '{valid: 1'b1, rd: id_rd, wr_en: id_wr_en, is_load: id_is_load};
        sel_a <= pick_src(id_rs_a, id_use_a, ex_q, mem_q, wb_q);
        sel_b <= pick_src(id_rs_b, id_use_b, ex_q, mem_q, wb_q);
      end else begin
        ex_q  <= '0;
        sel_a <= SEL_RF;
        sel_b <= SEL_RF;
      end
      bubble <= id_valid && (stall || flush);
    end
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Scoreboard bench for fwd_sel_unit: directed vectors push expectations,
// a monitor pops and compares once per cycle on the falling edge.
module tb_fwd_sel_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [1:0] id_rs_a, id_rs_b, id_rd;
  logic       id_use_a, id_use_b, id_wr_en, id_is_load, flush;
  logic [1:0] sel_a, sel_b;
  logic       stall, bubble;
`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fwd_sel_unit dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs_a    (id_rs_a),
    .id_rs_b    (id_rs_b),
    .id_use_a   (id_use_a),
    .id_use_b   (id_use_b),
    .id_rd      (id_rd),
    .id_wr_en   (id_wr_en),
    .id_is_load (id_is_load),
    .flush      (flush),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .stall      (stall),
    .bubble     (bubble)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    int         idx;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       bub;
    logic       st;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_idx = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Each vector: inputs held for one cycle, plus the outputs expected during
  // that cycle (registered outputs reflect the previous cycle's inputs).
  task automatic step(input logic r, input logic v,
                      input logic [1:0] ra, input logic [1:0] rb,
                      input logic ua, input logic ub,
                      input logic [1:0] rd, input logic wr, input logic ld,
                      input logic fl,
                      input logic [1:0] esa, input logic [1:0] esb,
                      input logic ebub, input logic est, input int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs_a = ra; id_rs_b = rb;
    id_use_a = ua; id_use_b = ub; id_rd = rd; id_wr_en = wr;
    id_is_load = ld; flush = fl;
    vec_idx++;
    e.idx = vec_idx; e.sa = esa; e.sb = esb; e.bub = ebub; e.st = est; e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  // Monitor: compares one expectation per cycle and flags back-to-back stalls.
  initial begin
    exp_t e;
    logic prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("v%0d sel_a", e.idx), 32'(sel_a), 32'(e.sa));
        check($sformatf("v%0d sel_b", e.idx), 32'(sel_b), 32'(e.sb));
        check($sformatf("v%0d bubble", e.idx), 32'(bubble), 32'(e.bub));
        check($sformatf("v%0d stall", e.idx), 32'(stall), 32'(e.st));
`ifdef FWD_STALL_CNT_EN
        check($sformatf("v%0d stall_cnt", e.idx), 32'(stall_cnt), 32'(e.cnt));
`endif
        if (prev_stall)
          check($sformatf("v%0d repeat_stall", e.idx), 32'(stall), 32'd0);
        prev_stall = stall;
      end
    end
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs_a = '0; id_rs_b = '0;
    id_use_a = 1'b0; id_use_b = 1'b0; id_rd = '0; id_wr_en = 1'b0;
    id_is_load = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);

    //    r  v  ra rb ua ub rd wr ld fl   sa sb bub st cnt
    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    // ADD r1, then consumer of r1 on A -> 01
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0);
    step(0, 1, 1, 2, 1, 1, 2, 1, 0, 0,   0, 0, 0, 0, 0);
    // producer r2 (above), unrelated, then reads of r2 at distance 2/3/4
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0,   1, 0, 0, 0, 0);
    step(0, 1, 0, 2, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    step(0, 1, 0, 2, 0, 1, 0, 0, 0, 0,   0, 2, 0, 0, 0);
    step(0, 1, 3, 2, 1, 1, 0, 0, 0, 0,   0, 3, 0, 0, 0);
    // LOAD r3 then consumer -> stall, bubble, retry resolves to 10
    step(0, 1, 0, 0, 0, 0, 3, 1, 1, 0,   3, 0, 0, 0, 0);
    step(0, 1, 3, 0, 1, 0, 1, 1, 0, 0,   0, 0, 0, 1, 0);
    step(0, 1, 3, 0, 1, 0, 1, 1, 0, 0,   0, 0, 1, 0, 1);
    // r0 written twice, then read on both operands -> newest (01)
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1, 1, 2, 1, 0, 0,   0, 0, 0, 0, 1);
    // own rd as source only sees older slots
    step(0, 1, 1, 3, 1, 1, 1, 1, 0, 0,   1, 1, 0, 0, 1);
    // operands resolved from different slots
    step(0, 1, 1, 2, 1, 1, 3, 0, 0, 0,   0, 0, 0, 0, 1);
    // LOAD r2 reading r2 from WB; then hazard coincident with flush
    step(0, 1, 2, 0, 1, 0, 2, 1, 1, 0,   1, 2, 0, 0, 1);
    step(0, 1, 0, 2, 0, 1, 0, 1, 0, 1,   3, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    // load-use on operand B
    step(0, 1, 0, 0, 0, 0, 1, 1, 1, 0,   0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0, 1, 3, 1, 0, 0,   0, 0, 0, 1, 1);
    step(0, 1, 0, 1, 0, 1, 3, 1, 0, 0,   0, 0, 1, 0, 2);
    // reset asserted while a hazard is pending
    step(0, 1, 0, 0, 0, 0, 2, 1, 1, 0,   0, 2, 0, 0, 2);
    step(1, 1, 2, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2);
    step(0, 1, 2, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
